// File: rtl/vertex_transform_unit.sv
`default_nettype none
// ============================================================================
// Module      : vertex_transform_unit
// Description : Applies a 4x4 signed fixed-point transform (row-major, 256-bit
//               bus) to a stream of 4-component vertices, one matrix row per
//               cycle using four parallel MACs. Valid/ready on both sides.
// Ports       : CLK        clock, rising edge
//               rst        asynchronous active-low reset
//               mtx_valid  single-cycle load strobe for mtx_in
//               mtx_in     matrix, m11 at [255:240] ... m44 at [15:0]
//               in_valid   vertex present on in_vec
//               in_ready   block can accept a vertex this cycle
//               in_vec     {x,y,z,w}, x at [63:48]
//               out_valid  out_vec holds a finished result
//               out_ready  downstream accepts out_vec
//               out_vec    {x',y',z',w'}, same packing as in_vec
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_transform_unit #(
  parameter int DW   = 16,
  parameter int FRAC = 5
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            mtx_valid,
  input  logic [16*DW-1:0] mtx_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*DW-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*DW-1:0] out_vec
);

  localparam int SW = 2*DW + 2;  // sum of four full products without overflow

  localparam logic signed [SW-1:0] c_sat_hi = SW'((2**(DW-1)) - 1);
  localparam logic signed [SW-1:0] c_sat_lo = -c_sat_hi - SW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t             state;
  logic               mtx_loaded;
  logic [16*DW-1:0]   mtx_pend;
  logic [16*DW-1:0]   mtx_act;
  logic [4*DW-1:0]    vec;
  logic [1:0]         row;
  logic               accept;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic [DW-1:0]      row_res;

  assign in_ready = (state == IDLE) && mtx_loaded;
  assign accept   = in_valid && in_ready;

  // Dot product of the current matrix row with the latched vertex.
  always_comb begin
    logic signed [DW-1:0]   a;
    logic signed [DW-1:0]   b;
    logic signed [2*DW-1:0] prod;
    sum  = '0;
    a    = '0;
    b    = '0;
    prod = '0;
    for (int k = 0; k < 4; k++) begin
      a    = mtx_act[(15 - (4*int'(row) + k))*DW +: DW];
      b    = vec[(3 - k)*DW +: DW];
      prod = a * b;
      sum  = sum + SW'(prod);
    end
  end

  // Arithmetic shift truncates toward -inf, then clamp to the DW range.
  always_comb begin
    shifted = sum >>> FRAC;
    if (shifted > c_sat_hi) begin
      row_res = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < c_sat_lo) begin
      row_res = {1'b1, {(DW-1){1'b0}}};
    end else begin
      row_res = shifted[DW-1:0];
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mtx_loaded <= 1'b0;
      mtx_pend   <= '0;
      mtx_act    <= '0;
      vec        <= '0;
      row        <= 2'd0;
      out_valid  <= 1'b0;
      out_vec    <= '0;
    end else begin
      if (mtx_valid) begin
        mtx_pend   <= mtx_in;
        mtx_loaded <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            vec     <= in_vec;
            // A matrix arriving on the accept edge is used immediately.
            mtx_act <= mtx_valid ? mtx_in : mtx_pend;
            row     <= 2'd0;
            state   <= CALC;
          end
        end
        CALC: begin
          out_vec[(3 - int'(row))*DW +: DW] <= row_res;
          row <= row + 2'd1;
          if (row == 2'd3) begin
            state     <= OUT;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vertex_transform_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vertex_transform_unit
// Description : Self-checking bench for vertex_transform_unit. Expected
//               results are computed from an independent model and queued at
//               vertex acceptance; a monitor pops and compares on each output
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vertex_transform_unit;

  logic         CLK;
  logic         rst;
  logic         mtx_valid;
  logic [255:0] mtx_in;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_vec;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0]  sbq[$];
  logic [255:0] tb_mtx;

  vertex_transform_unit #(.DW(16), .FRAC(5)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .mtx_valid (mtx_valid),
    .mtx_in    (mtx_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit accumulate, arithmetic shift, clamp to 16 bits.
  function automatic logic [63:0] model(input logic [255:0] m, input logic [63:0] v);
    logic [63:0] r;
    logic [15:0] mm;
    logic [15:0] vv;
    longint      s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        mm = m[255 - 16*(4*i + k) -: 16];
        vv = v[63 - 16*k -: 16];
        s  = s + longint'($signed(mm)) * longint'($signed(vv));
      end
      s = s >>> 5;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[63 - 16*i -: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_mtx(input logic [255:0] m);
    mtx_in    = m;
    mtx_valid = 1'b1;
    tb_mtx    = m;
    tick();
    mtx_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] v);
    int n;
    n        = 0;
    in_vec   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check_val("send_ready", {63'd0, in_ready}, 64'd1);
    end else begin
      sbq.push_back(model(tb_mtx, v));
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; returns edges until out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) check_val("out_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  // Scoreboard: the handshake completes on the following rising edge.
  always @(negedge CLK) begin
    if (rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check_val("sb_empty", 64'(sbq.size()), 64'd1);
      end else begin
        check_val("sb_out", out_vec, sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [255:0] M_ID = {
    16'h0020, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0020, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0020, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0020};
  localparam logic [255:0] M_ROTY = {
    16'h0000, 16'h0000, 16'h0020, 16'h0000,
    16'h0000, 16'h0020, 16'h0000, 16'h0000,
    16'hFFE0, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0020};
  localparam logic [255:0] M_SAT = {16'h4000, 240'd0};
  localparam logic [255:0] M_X2 = {
    16'h0040, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0040, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0040, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0040};

  initial begin
    int          lat;
    logic [63:0] held;
    logic [255:0] rm;
    logic [63:0]  rv;

    rst       = 1'b0;
    mtx_valid = 1'b0;
    mtx_in    = '0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    tb_mtx    = '0;
    tick();
    tick();
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_val("rst_out_vec", out_vec, 64'd0);
    @(negedge CLK);
    rst = 1'b1;
    tick();

    // No matrix loaded: vertices must be refused.
    in_valid = 1'b1;
    in_vec   = 64'h0040_FFE0_0060_0020;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("nomtx_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("nomtx_out_valid", {63'd0, out_valid}, 64'd0);
    end
    in_valid = 1'b0;

    // Identity transform and latency.
    load_mtx(M_ID);
    send(64'h0040_FFE0_0060_0020);
    wait_out(lat);
    check_val("ident_latency", 64'(lat), 64'd4);
    check_val("ident_vec", out_vec, 64'h0040_FFE0_0060_0020);
    tick();
    check_val("ident_done", {63'd0, out_valid}, 64'd0);

    // 90-degree Y rotation.
    load_mtx(M_ROTY);
    send(64'h0020_0000_0000_0020);
    wait_out(lat);
    check_val("roty_vec", out_vec, 64'h0000_0000_FFE0_0020);
    tick();

    // Positive and negative saturation.
    load_mtx(M_SAT);
    send(64'h4000_0010_0020_0030);
    wait_out(lat);
    check_val("sat_pos", out_vec, 64'h7FFF_0000_0000_0000);
    tick();
    send(64'hC000_0000_0000_0000);
    wait_out(lat);
    check_val("sat_neg", out_vec, 64'h8000_0000_0000_0000);
    tick();

    // Back-pressure with a matrix swap while the result is held.
    load_mtx(M_ID);
    out_ready = 1'b0;
    send(64'h0001_0002_0003_0004);
    wait_out(lat);
    held     = model(M_ID, 64'h0001_0002_0003_0004);
    in_vec   = 64'h0010_0020_0030_0040;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        load_mtx(M_X2);
      end else begin
        tick();
      end
      check_val("bp_vec", out_vec, held);
      check_val("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    send(64'h0010_0020_0030_0040);
    wait_out(lat);
    check_val("swap_vec", out_vec, 64'h0020_0040_0060_0080);
    tick();

    // Random matrices and vertices through the scoreboard.
    for (int j = 0; j < 3; j++) begin
      for (int e = 0; e < 16; e++) rm[16*e +: 16] = 16'($urandom);
      load_mtx(rm);
      for (int i = 0; i < 3; i++) begin
        rv = {32'($urandom), 32'($urandom)};
        send(rv);
        wait_out(lat);
        check_val("rand_latency", 64'(lat), 64'd4);
        tick();
      end
    end

    // Reset during CALC row 2.
    load_mtx(M_ID);
    send(64'h0100_0200_0300_0400);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("arst_in_ready", {63'd0, in_ready}, 64'd0);
    check_val("arst_out_vec", out_vec, 64'd0);
    sbq.delete();
    @(negedge CLK);
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    end
    in_valid = 1'b0;
    load_mtx(M_X2);
    send(64'h0100_0200_0300_0400);
    wait_out(lat);
    check_val("post_rst_vec", out_vec, 64'h0200_0400_0600_0800);
    tick();
    tick();

    check_val("sb_drain", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
